keypad_entry: RTL and testbench

- Input-side counterpart to the seven-segment display scanner in the digital clock.
- Drives a 4x4 matrix keypad with a rotating one-hot column strobe, samples the rows, debounces, and decodes keys.
- Assembles six BCD digits into hour/minute/second values for loading into the time counters.
- Also supplies the 2-bit function number NUM that the display shows on its leftmost digit.

---
 rtl/keypad_entry_pkg.sv | 40 ++++
 rtl/keypad_entry_if.sv | 32 +++
 rtl/keypad_entry_scan.sv | 134 +++++++++++++
 rtl/keypad_entry.sv | 106 ++++++++++
 tb/tb_keypad_entry.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg
//   Shared constants and helpers for the keypad entry block.
//   - key codes for the non-digit keys
//   - KEY_NONE: 5-bit scan-result encoding for "no key pressed"
//   - BCD upper limits used when validating a committed time
//   - commit_ok(): validity test for a six-digit hh:mm:ss entry
//   - is_repeatable(): keys that auto-repeat when KEYPAD_REPEAT_EN is defined
package keypad_entry_pkg;

    localparam logic [3:0] KEY_COMMIT = 4'd10;
    localparam logic [3:0] KEY_CLEAR  = 4'd11;
    localparam logic [3:0] KEY_MODE   = 4'd12;
    localparam logic [3:0] KEY_BKSP   = 4'd13;

    // Scan result: bit 4 set means no key. Any real key code {row,col}
    // compares lower than KEY_NONE, so "lowest pressed key" is a plain min().
    typedef logic [4:0] scan_t;
    localparam scan_t KEY_NONE = 5'h10;

    localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
    localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;

    localparam logic [2:0] DIGITS = 3'd6;

    function automatic logic commit_ok(input logic [23:0] e, input logic [2:0] cnt);
        logic ok;
        ok = (cnt == DIGITS) &&
             (e[23:16] <= BCD_HOUR_MAX) &&
             (e[15:8]  <= BCD_MINSEC_MAX) &&
             (e[7:0]   <= BCD_MINSEC_MAX);
        for (int i = 0; i < 6; i++)
            if (e[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic is_repeatable(input logic [3:0] c);
        return (c <= 4'd9) || (c == KEY_BKSP);
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if
//   Bundles the keypad matrix lines and the decoded/assembled outputs of
//   keypad_entry.
//   master : the keypad_entry block (samples row, drives everything else)
//   slave  : keypad model / display / time counters (drives row)
//   Signals: row[3:0], col[3:0], key_code[3:0], key_valid, entry[23:0],
//            hour[7:0], minute[7:0], second[7:0], load, err, NUM[1:0]
interface keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [23:0] entry;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic        load;
    logic        err;
    logic [1:0]  NUM;

    modport master (
        input  row,
        output col, key_code, key_valid, entry, hour, minute, second,
               load, err, NUM
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, entry, hour, minute, second,
               load, err, NUM
    );
endinterface

// File: rtl/keypad_entry_scan.sv
// keypad_entry_scan
//   Keypad scan and debounce: rotates a one-hot column strobe, synchronises
//   and samples the rows, reduces each full scan to the lowest pressed code,
//   debounces scan results and emits one key_valid pulse per accepted key.
//   Optional macro KEYPAD_REPEAT_EN: held digit/backspace keys re-pulse
//   after 32 full scans, then every 8 full scans.
//   Ports:
//     CP        in   clock
//     RST       in   synchronous reset, active-high
//     row[3:0]  in   raw keypad rows (asynchronous)
//     col[3:0]  out  one-hot column strobe
//     key_code  out  accepted key {row_idx, col_idx}
//     key_valid out  one-cycle pulse per accepted (or repeated) key
module keypad_entry_scan
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic       CP,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_SCANS + 1);

    logic [DW-1:0] div;
    logic [1:0]    cidx;
    logic [3:0]    row_s1, row_s2;
    scan_t         acc;       // running minimum over the current scan
    scan_t         prev;      // previous full-scan result
    scan_t         acc_st;    // accepted (debounced) state
    logic [CW-1:0] deb;

    logic          last, scan_done, accept;
    scan_t         cand, result;
    logic [CW-1:0] deb_nxt;

    assign col = 4'b0001 << cidx;

    always_comb begin
        last      = (div == DW'(SCAN_DIV - 1));
        scan_done = last && (cidx == 2'd3);

        // Lowest pressed row in the active column gives the lowest code there.
        cand = KEY_NONE;
        if      (row_s2[0]) cand = {1'b0, 2'd0, cidx};
        else if (row_s2[1]) cand = {1'b0, 2'd1, cidx};
        else if (row_s2[2]) cand = {1'b0, 2'd2, cidx};
        else if (row_s2[3]) cand = {1'b0, 2'd3, cidx};

        result = (cand < acc) ? cand : acc;

        if (result != prev)
            deb_nxt = CW'(1);
        else if (deb == CW'(DEB_SCANS))
            deb_nxt = deb;
        else
            deb_nxt = deb + CW'(1);

        accept = scan_done && (deb_nxt == CW'(DEB_SCANS)) && (result != acc_st);
    end

`ifdef KEYPAD_REPEAT_EN
    logic [5:0] rpt_cnt;
    logic       rpt_first;   // still waiting for the long initial delay
`endif

    always_ff @(posedge CP) begin
        if (RST) begin
            div       <= '0;
            cidx      <= 2'd0;
            row_s1    <= 4'd0;
            row_s2    <= 4'd0;
            acc       <= KEY_NONE;
            prev      <= KEY_NONE;
            acc_st    <= KEY_NONE;
            deb       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= 6'd0;
            rpt_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            row_s1    <= row;
            row_s2    <= row_s1;
            div       <= last ? '0 : div + DW'(1);

            if (last) begin
                cidx <= cidx + 2'd1;
                acc  <= scan_done ? KEY_NONE : result;
            end

            if (scan_done) begin
                prev <= result;
                deb  <= deb_nxt;
                if (accept) begin
                    acc_st <= result;
                    if (!result[4]) begin
                        key_code  <= result[3:0];
                        key_valid <= 1'b1;
                    end
                end
`ifdef KEYPAD_REPEAT_EN
                // Repeat timing counts full scans that still see the
                // accepted key; any other result restarts the long delay.
                if (accept) begin
                    rpt_cnt   <= 6'd0;
                    rpt_first <= 1'b1;
                end else if (!acc_st[4] && (result == acc_st) &&
                             is_repeatable(acc_st[3:0])) begin
                    if (rpt_cnt == (rpt_first ? 6'd31 : 6'd7)) begin
                        rpt_cnt   <= 6'd0;
                        rpt_first <= 1'b0;
                        key_valid <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 6'd1;
                    end
                end else begin
                    rpt_cnt   <= 6'd0;
                    rpt_first <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
//   Keypad input block for the digital clock: scans a 4x4 matrix keypad,
//   debounces and decodes keys, assembles six BCD digits into an
//   hh:mm:ss value and loads it on commit; also steps the display
//   function number NUM.
//   Optional macro KEYPAD_REPEAT_EN (handled in keypad_entry_scan):
//   auto-repeat of held digit/backspace keys.
//   Ports:
//     CP   in  clock
//     RST  in  synchronous reset, active-high
//     bus  keypad_entry_if.master: row in; col, key_code, key_valid,
//          entry, hour, minute, second, load, err, NUM out
//   Key actions take effect on the cycle after key_valid.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic           CP,
    input  logic           RST,
    keypad_entry_if.master bus
);

    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [23:0] entry;
    logic [2:0]  cnt;
    logic [7:0]  hour, minute, second;
    logic        load, err;
    logic [1:0]  num;

    keypad_entry_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) u_scan (
        .CP        (CP),
        .RST       (RST),
        .row       (bus.row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always_ff @(posedge CP) begin
        if (RST) begin
            entry  <= 24'd0;
            cnt    <= 3'd0;
            hour   <= 8'd0;
            minute <= 8'd0;
            second <= 8'd0;
            load   <= 1'b0;
            err    <= 1'b0;
            num    <= 2'd0;
        end else begin
            load <= 1'b0;
            err  <= 1'b0;
            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    // Shift in newest digit; oldest falls off once full.
                    entry <= {entry[19:0], key_code};
                    cnt   <= (cnt == DIGITS) ? DIGITS : cnt + 3'd1;
                end else begin
                    case (key_code)
                        KEY_COMMIT: begin
                            if (commit_ok(entry, cnt)) begin
                                hour   <= entry[23:16];
                                minute <= entry[15:8];
                                second <= entry[7:0];
                                load   <= 1'b1;
                                entry  <= 24'd0;
                                cnt    <= 3'd0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        KEY_CLEAR: begin
                            entry <= 24'd0;
                            cnt   <= 3'd0;
                        end
                        KEY_MODE: num <= num + 2'd1;
                        KEY_BKSP: begin
                            entry <= {4'h0, entry[23:4]};
                            cnt   <= (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
                        end
                        default: ;  // 14, 15: accepted but no action
                    endcase
                end
            end
        end
    end

    assign bus.col       = col;
    assign bus.key_code  = key_code;
    assign bus.key_valid = key_valid;
    assign bus.entry     = entry;
    assign bus.hour      = hour;
    assign bus.minute    = minute;
    assign bus.second    = second;
    assign bus.load      = load;
    assign bus.err       = err;
    assign bus.NUM       = num;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//   Directed + randomized bench for keypad_entry with SCAN_DIV=4,
//   DEB_SCANS=2. A keypad model drives rows from the column strobe; a
//   digit-queue model predicts entry/commit/mode results per key press.
module tb_keypad_entry;

    localparam int SCAN = 16;   // cycles per full scan (4 columns x 4)

    logic CP  = 1'b0;
    logic RST = 1'b1;

    keypad_entry_if kif ();

    keypad_entry #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (
        .CP  (CP),
        .RST (RST),
        .bus (kif)
    );

    always #5 CP = ~CP;

    // Keypad: one key at a time, closing row drv_code[3:2] when its column is strobed.
    logic       key_down = 1'b0;
    logic [3:0] drv_code = 4'd0;
    assign kif.row = (key_down && kif.col[drv_code[1:0]]) ? (4'b0001 << drv_code[3:2]) : 4'b0000;

    int checks = 0;
    int errors = 0;

    // Output event monitor, sampled away from the active edge.
    int         kv_cnt = 0, load_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [3:0] kv_last = 4'd0;
    always @(negedge CP) begin
        if (kif.key_valid) begin
            kv_cnt  <= kv_cnt + 1;
            kv_last <= kif.key_code;
        end
        if (kif.load) load_cnt <= load_cnt + 1;
        if (kif.err)  err_cnt  <= err_cnt + 1;
        if (kif.load && kif.err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending digits oldest-first, plus committed time and mode.
    int         q[$];
    logic [7:0] m_hour = 8'd0, m_min = 8'd0, m_sec = 8'd0;
    int         m_num = 0;

    function automatic logic [23:0] m_entry();
        logic [23:0] e = 24'd0;
        foreach (q[i]) e = (e << 4) | 24'(q[i]);
        return e;
    endfunction

    task automatic model_key(input int c, output int exp_load, output int exp_err);
        exp_load = 0;
        exp_err  = 0;
        if (c <= 9) begin
            q.push_back(c);
            if (q.size() > 6) void'(q.pop_front());
        end else if (c == 10) begin
            if (q.size() == 6 && q[0]*10 + q[1] <= 23 &&
                q[2]*10 + q[3] <= 59 && q[4]*10 + q[5] <= 59) begin
                m_hour   = 8'(q[0]*16 + q[1]);
                m_min    = 8'(q[2]*16 + q[3]);
                m_sec    = 8'(q[4]*16 + q[5]);
                exp_load = 1;
                q.delete();
            end else begin
                exp_err = 1;
            end
        end else if (c == 11) begin
            q.delete();
        end else if (c == 12) begin
            m_num = (m_num + 1) % 4;
        end else if (c == 13) begin
            if (q.size() > 0) void'(q.pop_back());
        end
    endtask

    // Hold a key for 'hold' scans, release long enough to debounce, then check.
    task automatic press(input int c, input int hold);
        int kv0, ld0, er0, el, ee;
        kv0 = kv_cnt; ld0 = load_cnt; er0 = err_cnt;
        drv_code = 4'(c);
        key_down = 1'b1;
        repeat (hold*SCAN) @(negedge CP);
        key_down = 1'b0;
        repeat (4*SCAN) @(negedge CP);
        model_key(c, el, ee);
        check($sformatf("pulses[%0d]", c), 32'(kv_cnt - kv0), 32'd1);
        check($sformatf("key_code[%0d]", c), 32'(kv_last), 32'(c));
        check($sformatf("entry[%0d]", c), 32'(kif.entry), 32'(m_entry()));
        check($sformatf("load[%0d]", c), 32'(load_cnt - ld0), 32'(el));
        check($sformatf("err[%0d]", c), 32'(err_cnt - er0), 32'(ee));
        check($sformatf("hms[%0d]", c), {8'd0, kif.hour, kif.minute, kif.second},
              {8'd0, m_hour, m_min, m_sec});
        check($sformatf("NUM[%0d]", c), 32'(kif.NUM), 32'(m_num));
    endtask

    initial begin
        int bad, kv0, c;
        int mode_seq[5];

        // Reset, then idle: column strobe pattern and quiet outputs.
        repeat (3) @(posedge CP);
        @(negedge CP);
        check("rst_col", 32'(kif.col), 32'h1);
        check("rst_outs", {kif.key_valid, kif.load, kif.err, kif.NUM, kif.key_code},
              32'd0);
        check("rst_data", 32'(kif.entry | {kif.hour, kif.minute, kif.second}), 32'd0);
        RST = 1'b0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (kif.col !== (4'b0001 << ((n / 4) % 4))) bad++;
            @(negedge CP);
        end
        check("idle_col_pattern", 32'(bad), 32'd0);
        check("idle_no_pulse", 32'(kv_cnt), 32'd0);
        check("idle_outs", {8'd0, kif.hour, kif.minute, kif.second}, 32'd0);
        check("idle_entry", 32'(kif.entry), 32'd0);

        // Single held key (row1/col2 = code 6) gives exactly one pulse.
        press(6, 5);

        // Valid commit 12:34:56.
        for (int d = 1; d <= 6; d++) press(d, 3);
        press(10, 3);

        // Invalid hour 25 -> err, then backspace.
        press(2, 3); press(5, 3);
        for (int d = 0; d < 4; d++) press(0, 3);
        press(10, 3);
        check("err_entry", 32'(kif.entry), 32'h250000);
        press(13, 3);
        check("bksp_entry", 32'(kif.entry), 32'h025000);

        // Mode steps 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            press(12, 3);
            mode_seq[i] = int'(kif.NUM);
        end
        check("mode_seq", 32'({mode_seq[0], mode_seq[1], mode_seq[2], mode_seq[3], mode_seq[4]} == {1, 2, 3, 0, 1}), 32'd1);

        // Randomized key presses against the model.
        for (int i = 0; i < 30; i++) begin
            c = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 15);
            press(c, $urandom_range(3, 6));
        end

        // Bouncing row0: state flips every scan, never stable for 2 scans.
        kv0 = kv_cnt;
        drv_code = 4'd0;
        for (int i = 0; i < 6; i++) begin
            key_down = (i % 2 == 0);
            repeat (SCAN) @(negedge CP);
        end
        key_down = 1'b0;
        repeat (4*SCAN) @(negedge CP);
        check("bounce_no_pulse", 32'(kv_cnt - kv0), 32'd0);

        // Reset mid-scan and mid-debounce.
        press(7, 3);
        drv_code = 4'd9;
        key_down = 1'b1;
        repeat (SCAN + 6) @(negedge CP);
        kv0 = kv_cnt;
        RST = 1'b1;
        @(negedge CP);
        check("midrst_col", 32'(kif.col), 32'h1);
        check("midrst_entry", 32'(kif.entry), 32'd0);
        check("midrst_outs", {kif.key_valid, kif.load, kif.err, kif.NUM, kif.hour}, 32'd0);
        repeat (3) @(negedge CP);
        key_down = 1'b0;
        RST = 1'b0;
        repeat (4*SCAN) @(negedge CP);
        check("midrst_no_pulse", 32'(kv_cnt - kv0), 32'd0);
        check("load_err_exclusive", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
